// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path.
// The mode encodings match what the upstream logic stage drives.
package seg7_pkg;
  localparam logic [2:0] MODE_CNT  = 3'b100;
  localparam logic [2:0] MODE_WR   = 3'b010;
  localparam logic [2:0] MODE_RD   = 3'b001;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low segment decoder.
// Output bit order is {g,f,e,d,c,b,a}.
module hex7seg_decode (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'b1111111;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with per-frame input snapshot.
// Outputs are registered: they reflect the slot counter and digit index one cycle late.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV      = 100_000,  // must be >= GUARD+1
  parameter int GUARD    = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [2:0]  state_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   dsnap_q, dsnap_d;
  logic [2:0]    ssnap_q, ssnap_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          slot_end;
  logic [3:0]    nibble;
  logic [6:0]    seg_hex;
  logic [7:0]    lz;

  assign slot_end = (cnt_q == CW'(DIV - 1));
  assign nibble   = dsnap_q[{idx_q, 2'b00} +: 4];

  // lz[k]: nibbles k..7 of the snapshot are all zero; digit 0 is never blanked.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz[gi] = 1'b0;
      end else begin : g_rest
        assign lz[gi] = ~|dsnap_q[31:4*gi];
      end
    end
  endgenerate

  hex7seg_decode u_dec (
    .nib_i (nibble),
    .seg_o (seg_hex)
  );

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
    idx_d   = slot_end ? idx_q + 3'd1 : idx_q;
    dsnap_d = dsnap_q;
    ssnap_d = ssnap_q;
    an_d    = 8'hFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;

    if (slot_end && (idx_q == 3'd7)) begin
      dsnap_d = data_i;
      ssnap_d = state_i;
    end

    if (cnt_q >= CW'(GUARD)) begin
      case (ssnap_q)
        MODE_CNT: begin
          if (!((BLANK_LZ != 0) && lz[idx_q])) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = seg_hex;
          end
        end
        MODE_WR, MODE_RD: begin
          an_d  = ~(8'd1 << idx_q);
          seg_d = seg_hex;
          if ((idx_q == 3'd4) || ((ssnap_q == MODE_RD) && (idx_q == 3'd0))) begin
            dp_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      dsnap_q <= '0;
      ssnap_q <= '0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dsnap_q <= dsnap_d;
      ssnap_q <= ssnap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIV=8, GUARD=2; a second instance has blanking off.
// Positions are tracked by a bench-side edge counter since reset release.
module tb_seg7_scan;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [2:0]  state_i = '0;
  logic [7:0]  an_o, an_nb;
  logic [6:0]  seg_o, seg_nb;
  logic        dp_o, dp_nb;

  int ecnt;
  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] exp_rd [8];

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  seg7_scan #(.DIV(DIV), .GUARD(GUARD), .BLANK_LZ(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .state_i(state_i),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );

  seg7_scan #(.DIV(DIV), .GUARD(GUARD), .BLANK_LZ(0)) dut_nb (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .state_i(state_i),
    .an_o(an_nb), .seg_o(seg_nb), .dp_o(dp_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Land on the negedge where outputs show frame f, digit k, slot cycle c.
  task automatic goto(input int f, input int k, input int c);
    int target;
    int guard_cnt;
    target = 64 * f + 8 * k + c + 1;
    guard_cnt = 0;
    while ((ecnt < target) && (guard_cnt < 2000)) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (ecnt != target) chk($sformatf("sync f%0d k%0d c%0d", f, k, c), ecnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e_an;
    exp_rd = '{SF, SE, SE, SB, S3, S0, S0, S0};

    #3 rst_i = 1'b1;
    #1;
    chk("rst an", an_o, 8'hFF);
    chk("rst seg", seg_o, 7'h7F);
    chk("rst dp", dp_o, 1'b1);

    state_i = 3'b100;
    data_i  = 32'h11111111;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    goto(0, 3, 4);
    chk("first frame blank", an_o, 8'hFF);
    goto(1, 3, 4);
    chk("pre-reset an", an_o, 8'hF7);
    chk("pre-reset seg", seg_o, S1);

    // asynchronous reset while idx=3, cnt=5
    rst_i = 1'b1;
    #1;
    chk("midslot rst an", an_o, 8'hFF);
    chk("midslot rst seg", seg_o, 7'h7F);
    chk("midslot rst dp", dp_o, 1'b1);

    data_i = 32'h000000A5;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        goto(0, k, c);
        chk($sformatf("f0 blank k%0d c%0d", k, c), an_o, 8'hFF);
      end

    // counter mode, leading-zero blanking
    goto(1, 0, 0); chk("guard c0 an", an_o, 8'hFF);
    goto(1, 0, 1); chk("guard c1 an", an_o, 8'hFF);
    goto(1, 0, 2); chk("d0 c2 an", an_o, 8'hFE);
    goto(1, 0, 3);
    chk("d0 seg", seg_o, S5);
    chk("d0 dp", dp_o, 1'b1);
    goto(1, 1, 3);
    chk("d1 an", an_o, 8'hFD);
    chk("d1 seg", seg_o, SA);
    goto(1, 2, 3);
    chk("d2 blank an", an_o, 8'hFF);
    chk("d2 noblank an", an_nb, 8'hFB);
    for (int k = 3; k < 8; k++) begin
      goto(1, k, 4);
      chk($sformatf("d%0d blank an", k), an_o, 8'hFF);
    end
    chk("d7 noblank an", an_nb, 8'h7F);
    chk("d7 noblank seg", seg_nb, S0);

    // read mode
    data_i  = 32'h0003BEEF;
    state_i = 3'b001;
    for (int k = 0; k < 8; k++) begin
      goto(2, k, 3);
      e_an = ~(8'd1 << k);
      chk($sformatf("rd d%0d an", k), an_o, e_an);
      chk($sformatf("rd d%0d seg", k), seg_o, exp_rd[k]);
      chk($sformatf("rd d%0d dp", k), dp_o, ((k == 0) || (k == 4)) ? 1'b0 : 1'b1);
    end

    // no tearing on a mid-frame data change
    data_i  = 32'h11111111;
    state_i = 3'b100;
    goto(3, 0, 3);
    chk("tear d0 seg", seg_o, S1);
    goto(3, 3, 0);
    data_i = 32'h22222222;
    for (int k = 3; k < 8; k++) begin
      goto(3, k, 3);
      chk($sformatf("tear old d%0d seg", k), seg_o, S1);
    end
    for (int k = 0; k < 7; k++) begin
      goto(4, k, 3);
      chk($sformatf("tear new d%0d seg", k), seg_o, S2);
    end
    goto(4, 7, 6);
    chk("tear new d7 seg", seg_o, S2);
    data_i = 32'h33333333;

    // full-frame scan timing; the change just before the snapshot edge is captured
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        goto(5, k, c);
        e_an = (c >= GUARD) ? ~(8'd1 << k) : 8'hFF;
        chk($sformatf("scan k%0d c%0d an", k, c), an_o, e_an);
        if (c == 3) chk($sformatf("scan k%0d seg", k), seg_o, S3);
        if ((k == 0) && (c == 0)) state_i = 3'b011;
      end

    // invalid modes blank the whole frame
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        goto(6, k, c);
        chk($sformatf("mode011 k%0d c%0d an", k, c), an_o, 8'hFF);
        if ((k == 0) && (c == 0)) state_i = 3'b000;
      end
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        goto(7, k, c);
        chk($sformatf("mode000 k%0d c%0d an", k, c), an_o, 8'hFF);
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
